// File: rtl/bcd_pkg.sv
// Shared definitions for the serial BCD subtractor: FSM encoding and digit constants.
package bcd_pkg;

    // Width of one packed BCD digit.
    localparam int DIGIT_W = 4;

    // Largest legal value of a BCD digit.
    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

    // Operation sequencing: wait for start, ripple through the digits, present the result.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage : bcd_pkg

// File: rtl/bcd_digit_sub.sv
// One-digit BCD subtractor with borrow in/out and an illegal-digit flag.
module bcd_digit_sub
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] x,
    input  logic [DIGIT_W-1:0] y,
    input  logic               bi,
    output logic [DIGIT_W-1:0] d,
    output logic               bo,
    output logic               bad
);

    // Difference carried in DIGIT_W+1 bits: x - y - bi always lies in
    // -16..15, so the top bit is a true sign and nothing wraps before the
    // +10 correction is applied.
    logic [DIGIT_W:0] t;

    assign t = {1'b0, x} - {1'b0, y} - {{DIGIT_W{1'b0}}, bi};

    // A negative difference borrows from the next digit and is folded back by +10.
    always_comb begin
        bo  = t[DIGIT_W];
        d   = bo ? (t[DIGIT_W-1:0] + 4'd10) : t[DIGIT_W-1:0];
        bad = (x > BCD_MAX) || (y > BCD_MAX);
    end

endmodule : bcd_digit_sub

// File: rtl/bcd_sub_serial.sv
// Digit-serial packed-BCD subtractor: one digit per clock, least-significant first.
module bcd_sub_serial
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
)
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [DIGIT_W*DIGITS-1:0] a,
    input  logic [DIGIT_W*DIGITS-1:0] b,
    input  logic                      bin,
    output logic [DIGIT_W*DIGITS-1:0] diff,
    output logic                      bout,
    output logic                      invalid,
    output logic                      busy,
    output logic                      done
);

    localparam int W     = DIGIT_W * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    // Control state
    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             borrow_q, borrow_d;
    logic             bad_q, bad_d;

    // Captured operands and the result being assembled digit by digit
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     res_q, res_d;

    // Registered outputs
    logic [W-1:0]     diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             invalid_q, invalid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Current digit slice fed to the shared digit subtractor
    logic [DIGIT_W-1:0] dig_x, dig_y, dig_d;
    logic               dig_bo, dig_bad;

    assign dig_x = a_q[int'(idx_q)*DIGIT_W +: DIGIT_W];
    assign dig_y = b_q[int'(idx_q)*DIGIT_W +: DIGIT_W];

    bcd_digit_sub u_digit (
        .x   (dig_x),
        .y   (dig_y),
        .bi  (borrow_q),
        .d   (dig_d),
        .bo  (dig_bo),
        .bad (dig_bad)
    );

    // Next-state and next-output decode for the IDLE/RUN/DONE sequence.
    always_comb begin
        // NOTE: every variable gets its hold value first so no path through
        // the case statement can leave one unassigned and infer a latch.
        state_d   = state_q;
        idx_d     = idx_q;
        borrow_d  = borrow_q;
        bad_d     = bad_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        diff_d    = diff_q;
        bout_d    = bout_q;
        invalid_d = invalid_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d      = a;
                    b_d      = b;
                    borrow_d = bin;
                    bad_d    = 1'b0;
                    idx_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = ST_RUN;
                end
            end

            ST_RUN: begin
                // diff stays frozen; the digit lands in the private result register.
                res_d[int'(idx_q)*DIGIT_W +: DIGIT_W] = dig_d;
                borrow_d = dig_bo;
                bad_d    = bad_q | dig_bad;
                idx_d    = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    // An illegal digit anywhere poisons the whole result.
                    invalid_d = bad_d;
                    diff_d    = bad_d ? '0   : res_d;
                    bout_d    = bad_d ? 1'b0 : dig_bo;
                    done_d    = 1'b1;
                    state_d   = ST_DONE;
                end
            end

            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and output registers; reset aborts any operation and wins over start.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every flop
        // samples the values from before this edge, independent of ordering.
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            borrow_q  <= 1'b0;
            bad_q     <= 1'b0;
            diff_q    <= '0;
            bout_q    <= 1'b0;
            invalid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            borrow_q  <= borrow_d;
            bad_q     <= bad_d;
            diff_q    <= diff_d;
            bout_q    <= bout_d;
            invalid_q <= invalid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Operand and scratch-result registers.
    always_ff @(posedge clk) begin
        // NOTE: these are deliberately left out of reset: they are always
        // rewritten by an accepted start before anything reads them, so a
        // reset would only add fan-out on the wide datapath.
        a_q   <= a_d;
        b_q   <= b_d;
        res_q <= res_d;
    end

    assign diff    = diff_q;
    assign bout    = bout_q;
    assign invalid = invalid_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule : bcd_sub_serial
